// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst sequencer for a single-port synchronous RAM
// (1-cycle registered read). Accepts a write or read command of
// cmd_len+1 beats, streams write data into the RAM or RAM data out through
// a 2-entry output buffer, then pulses done for one cycle.
//
// Optional build macro RAM_BURST_WRAP_CHK_EN: when defined, a command whose
// last address would pass the top of the RAM is rejected at acceptance with
// done+err and no RAM access. When undefined, addresses wrap and err is 0.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// WRITE | accepting write beats into the RAM
// READ  | issuing RAM reads and draining the output buffer
// DONE  | one-cycle completion pulse (done, err)
module ram_burst_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic                  done,
    output logic                  err,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int CNT_W = LEN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]      rem_q, rem_d;        // beats still to transfer
    logic [CNT_W-1:0]      iss_rem_q, iss_rem_d; // reads still to issue
    logic                  inflight_q;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  wr_idx_q, rd_idx_q;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  pop;
    logic                  issue;
    logic [2:0]            level;
    logic                  wrap_err;

`ifdef RAM_BURST_WRAP_CHK_EN
    localparam int SUM_W = ADDR_WIDTH + LEN_WIDTH + 1;
    logic [SUM_W-1:0] end_addr;
    assign end_addr = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
    assign wrap_err = end_addr > SUM_W'({ADDR_WIDTH{1'b1}});
`else
    assign wrap_err = 1'b0;
`endif

    // Stream and RAM-side outputs follow the current state directly.
    assign cmd_ready   = cmd_ready_q;
    assign done        = done_q;
    assign err         = err_q;
    assign wdata_ready = (state_q == WRITE);
    assign ram_we      = (state_q == WRITE) && wdata_valid;
    assign ram_din     = (state_q == WRITE) ? wdata : '0;
    assign ram_addr    = ptr_q;
    assign rdata_valid = (occ_q != 2'd0);
    assign rdata       = buf_q[rd_idx_q];

    assign accept = cmd_valid && cmd_ready_q;
    assign pop    = rdata_valid && rdata_ready;
    // Buffer slots committed after this edge; a read may only be issued if
    // its data is guaranteed a slot when it returns.
    assign level  = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign issue  = (state_q == READ) && (iss_rem_q != '0) && (level < 3'd2);
    assign occ_d  = occ_q + 2'(inflight_q) - 2'(pop);

    // Next-state and counter update for the burst sequencer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        iss_rem_d = iss_rem_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ptr_d     = cmd_addr;
                    rem_d     = CNT_W'(cmd_len) + CNT_W'(1);
                    iss_rem_d = CNT_W'(cmd_len) + CNT_W'(1);
                    if (wrap_err) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = cmd_wr ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                if (wdata_valid) begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = DONE;
                end
            end
            READ: begin
                if (issue) begin
                    ptr_d     = ptr_q + ADDR_WIDTH'(1);
                    iss_rem_d = iss_rem_q - CNT_W'(1);
                end
                if (pop) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
        done_d      = (state_d == DONE);
    end

    // State, counters, registered handshake outputs and the read buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            iss_rem_q   <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_idx_q    <= 1'b0;
            rd_idx_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            iss_rem_q   <= iss_rem_d;
            inflight_q  <= issue;
            occ_q       <= occ_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            if (inflight_q) begin
                buf_q[wr_idx_q] <= ram_dout;
                wr_idx_q        <= ~wr_idx_q;
            end
            if (pop) rd_idx_q <= ~rd_idx_q;
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: behavioural RAM plus a reference memory image.
// Each burst is modelled as "beat k touches address (addr+k) mod 2**AW";
// writes update the image, reads are expected to return it in order.
module tb_ram_burst_ctrl;

    localparam int AW = 10;
    localparam int DW = 4;
    localparam int LW = 4;
    localparam int N  = 1 << AW;
    localparam bit [5:0] PAT = 6'b101001; // rdata_ready 1,0,0,1,0,1,...

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [DW-1:0] wdata = '0;
    logic          wdata_valid = 1'b0;
    logic          wdata_ready;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          rdata_ready = 1'b0;
    logic          done;
    logic          err;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem [N] = '{default: '0};
    logic [DW-1:0] ref_mem [N] = '{default: '0};

    int n_checks = 0;
    int n_pass   = 0;

    ram_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .done(done), .err(err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_wdata_ready"}, wdata_ready, 0);
        check({tag, "_rdata_valid"}, rdata_valid, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_ram_we"}, ram_we, 0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_din"}, ram_din, 0);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        cmd_valid   = 1'b0;
        wdata_valid = 1'b0;
        rdata_ready = 1'($urandom_range(0, 1));
        #1;
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_done", done, 0);
        check("idle_ram_we", ram_we, 0);
        check("idle_wdata_ready", wdata_ready, 0);
        check("idle_rdata_valid", rdata_valid, 0);
    endtask

    // dmode 0: beat k carries k+1, else random. vmode 0: wdata_valid always 1.
    // rmode 0: ready always, 1: fixed pattern, 2: random.
    task automatic burst(input bit wr, input int addr, input int len, input int dmode,
                         input int vmode, input int rmode, input bit hold, input bit chk_lat);
        int k, cyc, a;
        bit fin, ovf, held;
        logic [DW-1:0] held_d;
        ovf = 1'b0;
`ifdef RAM_BURST_WRAP_CHK_EN
        ovf = (addr + len > N - 1);
`endif
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_wr      = wr;
        cmd_addr    = AW'(addr);
        cmd_len     = LW'(len);
        wdata_valid = 1'b0;
        rdata_ready = 1'b0;
        #1;
        check("cmd_ready_accept", cmd_ready, 1);
        k = 0; cyc = 0; fin = 1'b0; held = 1'b0; held_d = '0;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!hold) cmd_valid = 1'b0;
            wdata_valid = wr && (vmode == 0 || $urandom_range(0, 1) == 1);
            wdata       = (dmode == 0) ? DW'(k + 1) : DW'($urandom);
            rdata_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? PAT[(cyc - 1) % 6]
                                                              : 1'($urandom_range(0, 1));
            #1;
            check("cmd_ready_busy", cmd_ready, 0);
            a = (addr + k) % N;
            if (ovf || k > len) begin
                check("done", done, 1);
                check("err", err, ovf);
                check("ram_we_done", ram_we, 0);
                check("wdata_ready_done", wdata_ready, 0);
                check("rdata_valid_done", rdata_valid, 0);
                if (chk_lat && !ovf) check("done_latency", cyc, wr ? len + 2 : len + 4);
                fin = 1'b1;
            end else if (wr) begin
                check("done_early", done, 0);
                check("wdata_ready", wdata_ready, 1);
                check("ram_we", ram_we, wdata_valid);
                if (wdata_valid) begin
                    check("ram_addr", ram_addr, a);
                    check("ram_din", ram_din, wdata);
                    ref_mem[a] = wdata;
                    k++;
                end
            end else begin
                check("done_early", done, 0);
                check("ram_we_read", ram_we, 0);
                check("wdata_ready_read", wdata_ready, 0);
                if (held) begin
                    check("rdata_hold_valid", rdata_valid, 1);
                    check("rdata_hold", rdata, held_d);
                end
                if (chk_lat) check("rdata_valid_lat", rdata_valid, cyc >= 3);
                if (rdata_valid && rdata_ready) begin
                    check("rdata", rdata, ref_mem[a]);
                    k++;
                end
                held   = rdata_valid && !rdata_ready;
                held_d = rdata;
            end
        end
        check("burst_completed", fin, 1);
    endtask

    initial begin
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("cmd_ready_after_rst", cmd_ready, 1);

        // Directed bursts: write 1..4 at 5, then read back unstalled and stalled.
        burst(1'b1, 5, 3, 0, 0, 0, 1'b0, 1'b1);
        idle_cycle();
        burst(1'b0, 5, 3, 0, 0, 0, 1'b0, 1'b1);
        idle_cycle();
        burst(1'b0, 5, 3, 0, 0, 1, 1'b0, 1'b0);
        idle_cycle();

        // Burst crossing the top of the address space.
        burst(1'b1, N - 2, 3, 0, 0, 0, 1'b0, 1'b1);
        idle_cycle();
        burst(1'b0, N - 2, 3, 0, 0, 0, 1'b0, 1'b0);
        idle_cycle();
        burst(1'b0, 0, 1, 0, 0, 2, 1'b0, 1'b0);
        idle_cycle();

        // Reset asserted during the second beat of a 4-beat write.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = AW'(100); cmd_len = LW'(3);
        #1;
        check("rst_burst_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0; wdata_valid = 1'b1; wdata = 4'h9;
        #1;
        check("rst_burst_beat1", ram_we, 1);
        ref_mem[100] = 4'h9;
        @(negedge clk);
        wdata = 4'h6;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        @(negedge clk);
        wdata_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("cmd_ready_after_midrst", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("no_done_after_abort", done, 0);
        end
        burst(1'b0, 100, 3, 0, 0, 2, 1'b0, 1'b0);
        idle_cycle();

        // cmd_valid held high: next command accepted only right after done.
        burst(1'b1, 200, 2, 1, 0, 0, 1'b1, 1'b0);
        burst(1'b1, 200, 2, 1, 1, 0, 1'b1, 1'b0);
        idle_cycle();

        // Randomized bursts, biased toward the top of the address space.
        for (int i = 0; i < 40; i++) begin
            int addr;
            addr = ($urandom_range(0, 3) == 0) ? N - 1 - $urandom_range(0, 7)
                                                : $urandom_range(0, N - 1);
            burst(1'($urandom_range(0, 1)), addr, $urandom_range(0, 15), 1,
                  $urandom_range(0, 1), $urandom_range(0, 2), 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
